// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - opcode-aware multi-cycle RV32I sequencer with memory stall and sticky fault
// Optional cycle/retired-instruction counters: define MULTICYCLE_CTRL_PERF_EN.
module multicycle_controller #(
  parameter int unsigned WAIT_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic [2:0]  stage,
  output logic        ir_en,
  output logic        reg_en,
  output logic        mem_req,
  output logic        mem_we,
  output logic        wen_reg,
  output logic        pc_en,
  output logic        select_op1,
  output logic        select_op2,
  output logic [1:0]  select_rdv,
  output logic        select_pc_value,
  output logic        select_address_src,
  output logic        fault
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [63:0] cycle_count,
  output logic [63:0] instret
`endif
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Timeout fires on the WAIT_TIMEOUT-th consecutive stalled cycle, unless ready arrives then.
  localparam logic [7:0] TIMEOUT_LAST = 8'(WAIT_TIMEOUT - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] wait_cnt;

  logic is_load;
  logic is_store;
  logic is_branch;
  logic is_legal;
  logic mem_phase;
  logic mem_wait;
  logic timeout;
  logic active;

  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);

  always_comb begin
    case (opcode)
      OP_RTYPE, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_legal = 1'b1;
      default:                           is_legal = 1'b0;
    endcase
  end

  assign active    = !rst;
  assign mem_phase = (state == S_FETCH) || (state == S_MEM);
  assign mem_wait  = mem_phase && !mem_ready;
  assign timeout   = mem_wait && (wait_cnt == TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= 8'd0;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        wait_cnt <= 8'd0;
      end else if (mem_wait) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: begin
        if (mem_ready) begin
          state_next = S_DECODE;
        end else if (timeout) begin
          state_next = S_FAULT;
        end
      end
      S_DECODE:    state_next = is_legal ? S_EXECUTE : S_FAULT;
      S_EXECUTE:   state_next = (is_load || is_store) ? S_MEM : S_WRITEBACK;
      S_MEM: begin
        if (mem_ready) begin
          state_next = S_WRITEBACK;
        end else if (timeout) begin
          state_next = S_FAULT;
        end
      end
      S_WRITEBACK: state_next = S_FETCH;
      S_FAULT:     state_next = S_FAULT;
      default:     state_next = S_FAULT;
    endcase
  end

  // Strobes are gated by rst so a reset mid-operation never leaks a write.
  always_comb begin
    stage              = active ? state : S_FETCH;
    ir_en              = 1'b0;
    reg_en             = 1'b0;
    mem_req            = 1'b0;
    mem_we             = 1'b0;
    wen_reg            = 1'b0;
    pc_en              = 1'b0;
    select_address_src = 1'b0;
    fault              = (state == S_FAULT);
    case (state)
      S_FETCH: begin
        mem_req = active;
        ir_en   = active && mem_ready;
      end
      S_DECODE: reg_en = active;
      S_MEM: begin
        mem_req            = active;
        mem_we             = active && is_store;
        select_address_src = 1'b1;
      end
      S_WRITEBACK: begin
        pc_en   = active;
        wen_reg = active && !is_store && !is_branch;
      end
      default: ;
    endcase
  end

  always_comb begin
    select_op1      = 1'b0;
    select_op2      = 1'b0;
    select_rdv      = 2'b00;
    select_pc_value = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        select_op1 = 1'b1;
        select_op2 = 1'b1;
        select_rdv = 2'b01;
      end
      OP_IALU: begin
        select_op1 = 1'b1;
        select_rdv = 2'b01;
      end
      OP_LOAD: begin
        select_op1 = 1'b1;
        select_rdv = 2'b11;
      end
      OP_STORE:  select_op1 = 1'b1;
      OP_BRANCH: select_pc_value = branch_taken;
      OP_JAL: begin
        select_rdv      = 2'b00;
        select_pc_value = 1'b1;
      end
      OP_JALR: begin
        select_op1      = 1'b1;
        select_rdv      = 2'b00;
        select_pc_value = 1'b1;
      end
      OP_LUI:   select_rdv = 2'b10;
      OP_AUIPC: select_rdv = 2'b01;
      default: ;
    endcase
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_count <= 64'd0;
      instret     <= 64'd0;
    end else begin
      if (state != S_FAULT) begin
        cycle_count <= cycle_count + 64'd1;
      end
      if (state == S_WRITEBACK) begin
        instret <= instret + 64'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller
// Expected cycle sequences are generated per instruction from its class and the stall counts chosen.
module tb_multicycle_controller;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       branch_taken = 1'b0;
  logic       mem_ready = 1'b0;
  logic [2:0] stage;
  logic       ir_en, reg_en, mem_req, mem_we, wen_reg, pc_en;
  logic       select_op1, select_op2, select_pc_value, select_address_src, fault;
  logic [1:0] select_rdv;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [63:0] cycle_count, instret;
`endif

  multicycle_controller #(.WAIT_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .stage(stage), .ir_en(ir_en), .reg_en(reg_en), .mem_req(mem_req), .mem_we(mem_we),
    .wen_reg(wen_reg), .pc_en(pc_en), .select_op1(select_op1), .select_op2(select_op2),
    .select_rdv(select_rdv), .select_pc_value(select_pc_value),
    .select_address_src(select_address_src), .fault(fault)
`ifdef MULTICYCLE_CTRL_PERF_EN
    , .cycle_count(cycle_count), .instret(instret)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] stage;
    logic ir_en, reg_en, mem_req, mem_we, wen_reg, pc_en, fault;
    bit   chk_fault, chk_sel, chk_addr;
    logic addr;
    logic [6:0] op;
    logic bt;
  } exp_t;

  typedef struct {
    bit c1; logic v1;
    bit c2; logic v2;
    bit cr; logic [1:0] vr;
    bit cp; logic vp;
  } sel_t;

  exp_t sb[$];
  int vectors = 0;
  int errors = 0;
  logic [6:0] cur_op = 7'd0;
  logic       cur_bt = 1'b0;

  logic [6:0] legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

  function automatic sel_t sel_model(input logic [6:0] op, input logic bt);
    sel_t s = '{default: '0};
    case (op)
      7'b0110011: s = '{1, 1'b1, 1, 1'b1, 1, 2'b01, 1, 1'b0};
      7'b0010011: s = '{1, 1'b1, 1, 1'b0, 1, 2'b01, 1, 1'b0};
      7'b0000011: s = '{1, 1'b1, 1, 1'b0, 1, 2'b11, 1, 1'b0};
      7'b0100011: s = '{1, 1'b1, 1, 1'b0, 0, 2'b00, 1, 1'b0};
      7'b1100011: s = '{1, 1'b0, 1, 1'b0, 0, 2'b00, 1, bt};
      7'b1101111: s = '{1, 1'b0, 1, 1'b0, 1, 2'b00, 1, 1'b1};
      7'b1100111: s = '{1, 1'b1, 1, 1'b0, 1, 2'b00, 1, 1'b1};
      7'b0110111: s = '{0, 1'b0, 0, 1'b0, 1, 2'b10, 1, 1'b0};
      7'b0010111: s = '{1, 1'b0, 1, 1'b0, 1, 2'b01, 1, 1'b0};
      default:    s = '{default: '0};
    endcase
    return s;
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic exp_t mk(input logic [2:0] s);
    exp_t e;
    e.stage = s;
    e.ir_en = 0; e.reg_en = 0; e.mem_req = 0; e.mem_we = 0; e.wen_reg = 0; e.pc_en = 0;
    e.fault = (s == 3'd5);
    e.chk_fault = 1;
    e.chk_sel = (s >= 3'd1) && (s <= 3'd4);
    e.chk_addr = (s == 3'd0) || (s == 3'd3);
    e.addr = (s == 3'd3);
    e.op = cur_op;
    e.bt = cur_bt;
    return e;
  endfunction

  task automatic step(input logic r, input logic rdy, input exp_t e);
    @(posedge clk); #1;
    rst = r; mem_ready = rdy; opcode = cur_op; branch_taken = cur_bt;
    sb.push_back(e);
  endtask

  function automatic logic rnd1();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic reset_cycle();
    exp_t e = mk(3'd0);
    e.chk_fault = 0; e.chk_sel = 0; e.chk_addr = 0;
    step(1'b1, rnd1(), e);
  endtask

  task automatic fetch_phase(input int fw);
    exp_t e;
    for (int i = 0; i < fw; i++) begin
      e = mk(3'd0); e.mem_req = 1; step(1'b0, 1'b0, e);
    end
    e = mk(3'd0); e.mem_req = 1; e.ir_en = 1; step(1'b0, 1'b1, e);
  endtask

  task automatic fault_phase();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      e = mk(3'd5); step(1'b0, rnd1(), e);
    end
    reset_cycle();
  endtask

  // mw >= TO stalls memory into timeout; abort_at >= 0 asserts rst after that many MEM cycles.
  task automatic run_instr(input logic [6:0] op, input logic bt, input int fw, input int mw,
                           input int abort_at = -1);
    exp_t e;
    bit ld, st;
    cur_op = op; cur_bt = bt;
    ld = (op == 7'b0000011); st = (op == 7'b0100011);
    if (fw >= TO) begin
      for (int i = 0; i < TO; i++) begin
        e = mk(3'd0); e.mem_req = 1; step(1'b0, 1'b0, e);
      end
      fault_phase();
      return;
    end
    fetch_phase(fw);
    e = mk(3'd1); e.reg_en = 1; step(1'b0, rnd1(), e);
    if (!is_legal(op)) begin
      fault_phase();
      return;
    end
    e = mk(3'd2); step(1'b0, rnd1(), e);
    if (ld || st) begin
      for (int i = 0; i < mw && i < TO; i++) begin
        if (i == abort_at) begin
          reset_cycle();
          return;
        end
        e = mk(3'd3); e.mem_req = 1; e.mem_we = st; step(1'b0, 1'b0, e);
      end
      if (mw >= TO) begin
        fault_phase();
        return;
      end
      e = mk(3'd3); e.mem_req = 1; e.mem_we = st; step(1'b0, 1'b1, e);
    end
    e = mk(3'd4); e.pc_en = 1; e.wen_reg = !(st || (op == 7'b1100011)); step(1'b0, rnd1(), e);
  endtask

  task automatic cmp(input string name, input logic [2:0] act, input logic [2:0] expv,
                     input logic [2:0] stg);
    if (act !== expv) begin
      errors++;
      $display("FAIL %s (expected stage %0d, t=%0t): got %0d, expected %0d", name, stg, $time, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      sel_t s;
      e = sb.pop_front();
      vectors++;
      cmp("stage", stage, e.stage, e.stage);
      cmp("ir_en", {2'b0, ir_en}, {2'b0, e.ir_en}, e.stage);
      cmp("reg_en", {2'b0, reg_en}, {2'b0, e.reg_en}, e.stage);
      cmp("mem_req", {2'b0, mem_req}, {2'b0, e.mem_req}, e.stage);
      cmp("mem_we", {2'b0, mem_we}, {2'b0, e.mem_we}, e.stage);
      cmp("wen_reg", {2'b0, wen_reg}, {2'b0, e.wen_reg}, e.stage);
      cmp("pc_en", {2'b0, pc_en}, {2'b0, e.pc_en}, e.stage);
      if (e.chk_fault) cmp("fault", {2'b0, fault}, {2'b0, e.fault}, e.stage);
      if (e.chk_addr) cmp("select_address_src", {2'b0, select_address_src}, {2'b0, e.addr}, e.stage);
      if (e.chk_sel) begin
        s = sel_model(e.op, e.bt);
        if (s.c1) cmp("select_op1", {2'b0, select_op1}, {2'b0, s.v1}, e.stage);
        if (s.c2) cmp("select_op2", {2'b0, select_op2}, {2'b0, s.v2}, e.stage);
        if (s.cr) cmp("select_rdv", {1'b0, select_rdv}, {1'b0, s.vr}, e.stage);
        if (s.cp) cmp("select_pc_value", {2'b0, select_pc_value}, {2'b0, s.vp}, e.stage);
      end
    end
  end

  initial begin
    reset_cycle();
    reset_cycle();
    run_instr(7'b0110011, 1'b0, 0, 0);
    run_instr(7'b0000011, 1'b0, 0, 3);
    run_instr(7'b0100011, 1'b0, 0, 0);
    run_instr(7'b1100011, 1'b1, 0, 0);
    run_instr(7'b1100011, 1'b0, 0, 0);
    run_instr(7'b1101111, 1'b0, 0, 0);
    run_instr(7'b0110111, 1'b0, 2, 0);
    run_instr(7'b1100111, 1'b0, 0, 0);
    run_instr(7'b0010111, 1'b0, 1, 0);
    run_instr(7'b0010011, 1'b0, 0, 0);
    run_instr(7'b0110011, 1'b0, TO, 0);
    run_instr(7'b0110011, 1'b0, TO - 1, 0);
    run_instr(7'b0000011, 1'b0, 0, TO);
    run_instr(7'b0100011, 1'b0, 0, TO - 1);
    run_instr(7'b0000000, 1'b0, 0, 0);
    run_instr(7'b0100011, 1'b0, 0, 2, 1);
    run_instr(7'b0100011, 1'b0, 0, 0, 0);
    run_instr(7'b0110011, 1'b0, 0, 0);
    for (int n = 0; n < 60; n++) begin
      logic [6:0] op;
      op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : legal_ops[$urandom_range(0, 8)];
      run_instr(op, rnd1(), ($urandom_range(0, 15) == 0) ? TO : $urandom_range(0, TO - 1),
                ($urandom_range(0, 15) == 0) ? TO : $urandom_range(0, TO - 1));
    end
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Central sequencer for the multi-cycle RV32I core. It replaces the free-running stage rotation with an opcode-aware FSM that has variable-length memory phases. It steps the datapath through fetch, decode, execute, memory and writeback. It issues one-cycle enable strobes to the instruction register, register file, memory and PC, and drives all datapath mux selects from the decoded opcode. It stalls on a memory ready handshake and enters a sticky fault state on a bus timeout or an illegal opcode.

Parameters:
WAIT_TIMEOUT, 16, max consecutive cycles of mem_req=1 with mem_ready=0 before fault (legal range 1..255)

Ports:
clk  input  1  core clock
rst  input  1  reset, synchronous, active-high
opcode  input  7  instruction[6:0] from instruction register; valid from DECODE onward
branch_taken  input  1  branch comparator result; valid in WRITEBACK
mem_ready  input  1  memory completes the current request this cycle
stage  output  3  state: 0 FETCH, 1 DECODE, 2 EXECUTE, 3 MEM, 4 WRITEBACK, 5 FAULT
ir_en  output  1  latch instruction into IR
reg_en  output  1  read/latch register file operands
mem_req  output  1  memory request active
mem_we  output  1  store write enable
wen_reg  output  1  register file write
pc_en  output  1  PC update strobe
select_op1  output  1  1=rs1v, 0=PC
select_op2  output  1  1=rs2v, 0=immediate
select_rdv  output  2  00 PC+4, 01 ALU, 10 imm, 11 mem read data
select_pc_value  output  1  1=PC loads ALU result, 0=PC+4
select_address_src  output  1  1=ALU address, 0=PC
fault  output  1  sticky fault flag

Behaviour:
- Reset: when rst=1 at a clk edge, state goes to FETCH, the wait counter clears, and fault clears. While rst is high, every strobe output (ir_en, reg_en, mem_req, mem_we, wen_reg, pc_en) is 0 and stage=0. Reset in any state, including mid-MEM, aborts the operation with no write.
- FETCH:
  - Outputs: mem_req=1, select_address_src=0.
  - When mem_ready=1: ir_en=1 in that same cycle (Mealy), then go to DECODE.
- DECODE:
  - Outputs: reg_en=1, one cycle.
  - Illegal opcode goes to FAULT. Otherwise go to EXECUTE.
- EXECUTE:
  - One cycle. Selects are valid.
  - Load (0000011) or store (0100011) goes to MEM. All other opcodes go to WRITEBACK.
- MEM:
  - Outputs: mem_req=1, select_address_src=1, mem_we=1 only for store.
  - Leave on mem_ready=1 and go to WRITEBACK.
- WRITEBACK:
  - Outputs: pc_en=1.
  - wen_reg=1 except for store and branch.
  - Go to FETCH.
- FAULT:
  - fault=1, all strobes 0, stage=5.
  - Exit only by rst.
- Selects: combinational from opcode; don't-care in FETCH.

| Opcode | select_op1 | select_op2 | select_rdv | select_pc_value |
|---|---|---|---|---|
| R-type 0110011 | 1 | 1 | 01 | 0 |
| I-ALU 0010011 | 1 | 0 | 01 | 0 |
| load | 1 | 0 | 11 | 0 |
| store | 1 | 0 | – | 0 |
| branch 1100011 | 0 | 0 | – | branch_taken |
| JAL 1101111 | 0 | 0 | 00 | 1 |
| JALR 1100111 | 1 | 0 | 00 | 1 |
| LUI 0110111 | – | – | 10 | 0 |
| AUIPC 0010111 | 0 | 0 | 01 | 0 |

- Any opcode not in the table above is illegal.
- Wait counter:
  - 8 bits. Clears on entry to FETCH or MEM.
  - Increments each cycle that mem_req=1 and mem_ready=0.
  - When it reaches WAIT_TIMEOUT, the next state is FAULT.
  - If mem_ready=1 in the same cycle as the timeout condition, ready wins: normal progress, no fault.
- Latency with zero-wait memory:
  - 4 cycles per non-memory instruction.
  - 5 cycles per load or store.
  - Each mem_ready=0 cycle adds one cycle.

Optional Feature:
- Macro MULTICYCLE_CTRL_PERF_EN.
- When defined, add two outputs:
  - cycle_count (64-bit): increments every clk when rst=0 and state≠FAULT.
  - instret (64-bit): increments on each WRITEBACK cycle.
  - Both reset to 0, wrap modulo 2^64, and freeze in FAULT.
- When undefined, the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
1. Reset, then ADD (0110011) with mem_ready=1 → stage sequence 0,1,2,4,0; select_op1=1, select_op2=1, select_rdv=01; wen_reg and pc_en high only at stage 4.
2. LW (0000011) with mem_ready held low for 3 MEM cycles → stage=3 for 4 cycles, mem_we=0, select_address_src=1, select_rdv=11; wen_reg=1 in WRITEBACK; 8 cycles total.
3. SW (0100011) → mem_we=1 only during MEM; wen_reg=0 in WRITEBACK; pc_en=1.
4. BEQ (1100011) with branch_taken=1, then again with branch_taken=0 → select_pc_value 1 then 0; wen_reg=0 both times. JAL → select_rdv=00, select_pc_value=1.
5. WAIT_TIMEOUT=4:
   - mem_ready=0 in FETCH → fault=1, stage=5 after 4 wait cycles; fault holds until rst, then FETCH.
   - Repeat with mem_ready=1 on the 4th cycle → no fault, goes to DECODE.
6. Opcode 0000000 → FAULT after DECODE. Separately, assert rst mid-MEM of a store → next cycle stage=0, mem_we=0, no wen_reg.
